// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: ROM read port, redirect request and the decode-side
// valid/ready instruction handshake.
interface instr_fetch_unit_if;
    logic        rom_nrd;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    // The fetch unit is the master side; ROM, branch unit and decode form the slave side.
    modport master (
        output rom_nrd, rom_addr, inst_valid, inst, inst_pc,
        input  rom_data, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  rom_nrd, rom_addr, inst_valid, inst, inst_pc,
        output rom_data, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads big-endian words from the ROM into
// a 2-entry queue, and handles redirects, halt opcode and illegal fetch addresses.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ROM_BYTES   = 100,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master fetch,
    output logic               halted,
    output logic               fault
);

    typedef enum logic [1:0] {StRun, StHalt, StFault} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] head_inst_q, head_inst_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] tail_inst_q, tail_inst_d;
    logic [31:0] tail_pc_q, tail_pc_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic        fault_q, fault_d;

    logic        deq;
    logic        room;
    logic        addr_legal;
    logic        active;
    logic        do_fetch;
    logic        do_fault;
    logic        is_halt;
    logic        take_redirect;
    logic [32:0] pc_last_byte;

    // Widened so a PC near the top of the address space cannot wrap into range.
    assign pc_last_byte  = {1'b0, pc_q} + 33'd3;
    assign addr_legal    = (pc_q[1:0] == 2'b00) && (pc_last_byte < 33'(ROM_BYTES));

    assign deq           = valid_q & fetch.inst_ready;
    assign room          = (count_q != 2'd2) || deq;
    assign active        = (state_q == StRun) && !fetch.redirect_valid && !rst;
    assign do_fetch      = active && addr_legal && room;
    assign do_fault      = active && !addr_legal;
    assign is_halt       = (fetch.rom_data[31:26] == HALT_OPCODE);
    assign take_redirect = fetch.redirect_valid && (state_q != StFault);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        count_d     = count_q;
        head_inst_d = head_inst_q;
        head_pc_d   = head_pc_q;
        tail_inst_d = tail_inst_q;
        tail_pc_d   = tail_pc_q;
        halted_d    = halted_q;
        fault_d     = fault_q;

        if (take_redirect) begin
            // Flush; any same-cycle dequeue is simply lost with the rest of the queue.
            count_d  = 2'd0;
            pc_d     = fetch.redirect_pc;
            state_d  = StRun;
            halted_d = 1'b0;
        end else begin
            unique case ({do_fetch, deq})
                2'b11: begin
                    if (count_q == 2'd2) begin
                        head_inst_d = tail_inst_q;
                        head_pc_d   = tail_pc_q;
                        tail_inst_d = fetch.rom_data;
                        tail_pc_d   = pc_q;
                    end else begin
                        head_inst_d = fetch.rom_data;
                        head_pc_d   = pc_q;
                    end
                end
                2'b01: begin
                    if (count_q == 2'd2) begin
                        head_inst_d = tail_inst_q;
                        head_pc_d   = tail_pc_q;
                    end
                    count_d = count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_inst_d = fetch.rom_data;
                        head_pc_d   = pc_q;
                    end else begin
                        tail_inst_d = fetch.rom_data;
                        tail_pc_d   = pc_q;
                    end
                    count_d = count_q + 2'd1;
                end
                default: ;
            endcase

            if (do_fetch) begin
                pc_d = pc_q + 32'd4;
                if (is_halt) begin
                    state_d  = StHalt;
                    halted_d = 1'b1;
                end
            end

            if (do_fault) begin
                state_d = StFault;
                fault_d = 1'b1;
            end
        end

        valid_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            pc_q        <= RESET_PC;
            count_q     <= 2'd0;
            head_inst_q <= 32'd0;
            head_pc_q   <= 32'd0;
            tail_inst_q <= 32'd0;
            tail_pc_q   <= 32'd0;
            valid_q     <= 1'b0;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            count_q     <= count_d;
            head_inst_q <= head_inst_d;
            head_pc_q   <= head_pc_d;
            tail_inst_q <= tail_inst_d;
            tail_pc_q   <= tail_pc_d;
            valid_q     <= valid_d;
            halted_q    <= halted_d;
            fault_q     <= fault_d;
        end
    end

    assign fetch.rom_nrd    = !do_fetch;
    assign fetch.rom_addr   = pc_q;
    assign fetch.inst_valid = valid_q;
    assign fetch.inst       = head_inst_q;
    assign fetch.inst_pc    = head_pc_q;
    assign halted           = halted_q;
    assign fault            = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: runs a small ROM program through streaming,
// backpressure, redirect, halt, illegal-address and reset scenarios.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic rst;
    logic halted;
    logic fault;
    int   n_vec = 0;
    int   n_err = 0;

    logic [31:0] rom_words [0:31];

    instr_fetch_unit_if bus();

    instr_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .ROM_BYTES   (100),
        .HALT_OPCODE (6'b111111)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .fetch  (bus),
        .halted (halted),
        .fault  (fault)
    );

    always #5 clk = ~clk;

    assign bus.rom_data = (bus.rom_addr < 32'd100) ? rom_words[bus.rom_addr[6:2]] : 32'hdead_beef;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) rom_words[i] = 32'h0000_0000;
        rom_words[0]  = 32'h2001_0001;
        rom_words[1]  = 32'h2001_0001;
        rom_words[2]  = 32'h2001_0001;
        rom_words[3]  = 32'hFC00_0000;
        rom_words[24] = 32'h1234_5678;

        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.inst_ready     = 1'b1;
        settle();
        check("nrd_in_reset", 32'(bus.rom_nrd), 32'd1);
        next_cycle();
        next_cycle();
        check("rst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_inst", bus.inst, 32'd0);
        check("rst_inst_pc", bus.inst_pc, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_addr", bus.rom_addr, 32'd0);

        // Streaming program with decode always ready.
        rst = 1'b0;
        settle();
        check("s0_nrd", 32'(bus.rom_nrd), 32'd0);
        check("s0_addr", bus.rom_addr, 32'd0);
        next_cycle(); settle();
        check("s1_valid", 32'(bus.inst_valid), 32'd1);
        check("s1_pc", bus.inst_pc, 32'd0);
        check("s1_inst", bus.inst, 32'h2001_0001);
        check("s1_addr", bus.rom_addr, 32'd4);
        next_cycle(); settle();
        check("s2_pc", bus.inst_pc, 32'd4);
        check("s2_addr", bus.rom_addr, 32'd8);
        next_cycle(); settle();
        check("s3_pc", bus.inst_pc, 32'd8);
        check("s3_nrd", 32'(bus.rom_nrd), 32'd0);
        check("s3_halted", 32'(halted), 32'd0);
        next_cycle(); settle();
        check("s4_pc", bus.inst_pc, 32'd12);
        check("s4_inst", bus.inst, 32'hFC00_0000);
        check("s4_halted", 32'(halted), 32'd1);
        check("s4_nrd", 32'(bus.rom_nrd), 32'd1);
        check("s4_addr", bus.rom_addr, 32'd16);
        next_cycle(); settle();
        check("s5_valid", 32'(bus.inst_valid), 32'd0);
        check("s5_nrd", 32'(bus.rom_nrd), 32'd1);
        check("s5_addr", bus.rom_addr, 32'd16);

        // Redirect out of HALT.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd0;
        settle();
        check("h_redir_nrd", 32'(bus.rom_nrd), 32'd1);
        next_cycle();
        bus.redirect_valid = 1'b0;
        settle();
        check("h1_halted", 32'(halted), 32'd0);
        check("h1_addr", bus.rom_addr, 32'd0);
        check("h1_nrd", 32'(bus.rom_nrd), 32'd0);
        check("h1_valid", 32'(bus.inst_valid), 32'd0);
        next_cycle(); settle();
        check("h2_valid", 32'(bus.inst_valid), 32'd1);
        check("h2_pc", bus.inst_pc, 32'd0);

        // Reset mid-operation discards the queue.
        rst = 1'b1;
        settle();
        check("mr_nrd", 32'(bus.rom_nrd), 32'd1);
        next_cycle(); settle();
        check("mr_valid", 32'(bus.inst_valid), 32'd0);
        check("mr_addr", bus.rom_addr, 32'd0);

        // Backpressure from reset.
        bus.inst_ready = 1'b0;
        next_cycle();
        rst = 1'b0;
        settle();
        check("b0_nrd", 32'(bus.rom_nrd), 32'd0);
        next_cycle(); settle();
        check("b1_pc", bus.inst_pc, 32'd0);
        check("b1_addr", bus.rom_addr, 32'd4);
        check("b1_nrd", 32'(bus.rom_nrd), 32'd0);
        next_cycle(); settle();
        check("b2_nrd", 32'(bus.rom_nrd), 32'd1);
        check("b2_addr", bus.rom_addr, 32'd8);
        next_cycle(); settle();
        check("b3_nrd", 32'(bus.rom_nrd), 32'd1);
        check("b3_pc", bus.inst_pc, 32'd0);
        bus.inst_ready = 1'b1;
        settle();
        check("b3_deq_nrd", 32'(bus.rom_nrd), 32'd0);
        check("b3_deq_addr", bus.rom_addr, 32'd8);

        // Redirect to 4 with a full queue (4, 8).
        next_cycle();
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd4;
        settle();
        check("r0_pc", bus.inst_pc, 32'd4);
        check("r0_nrd", 32'(bus.rom_nrd), 32'd1);
        next_cycle();
        bus.redirect_valid = 1'b0;
        bus.inst_ready     = 1'b1;
        settle();
        check("r1_valid", 32'(bus.inst_valid), 32'd0);
        check("r1_addr", bus.rom_addr, 32'd4);
        check("r1_nrd", 32'(bus.rom_nrd), 32'd0);
        next_cycle(); settle();
        check("r2_valid", 32'(bus.inst_valid), 32'd1);
        check("r2_pc", bus.inst_pc, 32'd4);
        check("r2_inst", bus.inst, 32'h2001_0001);

        // Misaligned redirect faults; later redirect ignored.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd6;
        next_cycle();
        bus.redirect_valid = 1'b0;
        settle();
        check("f1_addr", bus.rom_addr, 32'd6);
        check("f1_nrd", 32'(bus.rom_nrd), 32'd1);
        check("f1_fault", 32'(fault), 32'd0);
        check("f1_valid", 32'(bus.inst_valid), 32'd0);
        next_cycle(); settle();
        check("f2_fault", 32'(fault), 32'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd0;
        next_cycle();
        bus.redirect_valid = 1'b0;
        settle();
        check("f3_fault", 32'(fault), 32'd1);
        check("f3_addr", bus.rom_addr, 32'd6);
        check("f3_nrd", 32'(bus.rom_nrd), 32'd1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        settle();
        check("f4_fault", 32'(fault), 32'd0);
        check("f4_addr", bus.rom_addr, 32'd0);

        // Last legal word at 96, then 100 faults.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd96;
        next_cycle();
        bus.redirect_valid = 1'b0;
        settle();
        check("e1_addr", bus.rom_addr, 32'd96);
        check("e1_nrd", 32'(bus.rom_nrd), 32'd0);
        next_cycle(); settle();
        check("e2_valid", 32'(bus.inst_valid), 32'd1);
        check("e2_pc", bus.inst_pc, 32'd96);
        check("e2_inst", bus.inst, 32'h1234_5678);
        check("e2_addr", bus.rom_addr, 32'd100);
        check("e2_nrd", 32'(bus.rom_nrd), 32'd1);
        check("e2_fault", 32'(fault), 32'd0);
        next_cycle(); settle();
        check("e3_fault", 32'(fault), 32'd1);
        check("e3_valid", 32'(bus.inst_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
